// File: rtl/sram_port_arbiter_pkg.sv
// Shared definitions for the SRAM port arbiter: requester indices and FSM encoding.
package sram_port_arbiter_pkg;

  localparam int unsigned REQ_LDR = 0;
  localparam int unsigned REQ_SPI = 1;
  localparam int unsigned REQ_CPU = 2;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_OWN  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational one-hot picker: fixed priority (lowest index wins) or round-robin
// starting at the requester after ptr.
module rr_priority_pick #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  input  logic            mode,
  output logic [NREQ-1:0] gnt
);

  logic          found;
  logic [PW-1:0] idx;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = mode ? PW'((32'(ptr) + k + 1) % NREQ) : PW'(k);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Req/gnt arbiter sharing one single-port SRAM among NREQ requesters, with locked
// bursts, lock timeout, registered SRAM pins and a tagged read-valid pipe.
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int unsigned NREQ     = 3,
  parameter int unsigned AW       = 9,
  parameter int unsigned DW       = 8,
  parameter int unsigned LOCK_TMO = 64
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               ARB_EN,
  input  logic               RR_MODE,
  input  logic [NREQ-1:0]    REQ,
  input  logic [NREQ-1:0]    LOCK,
  input  logic [NREQ-1:0]    WE,
  input  logic [NREQ*AW-1:0] ADDR,
  input  logic [NREQ*DW-1:0] WDATA,
  output logic [NREQ-1:0]    GNT,
  output logic [NREQ-1:0]    RVALID,
  output logic [DW-1:0]      RDATA,
  output logic               LOCK_ERR,
  output logic               CEN,
  output logic               WEN,
  output logic [AW-1:0]      A,
  output logic [DW-1:0]      D,
  input  logic [DW-1:0]      Q
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = (LOCK_TMO > 1) ? $clog2(LOCK_TMO) : 1;

  arb_state_e    state_q, state_d;
  logic [PW-1:0] owner_q, owner_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          lock_err_q, lock_err_d;

  logic          cen_q, wen_q;
  logic [AW-1:0] a_q;
  logic [DW-1:0] d_q;
  logic          rd1_v_q, rd2_v_q;
  logic [PW-1:0] rd1_id_q, rd2_id_q;

  logic [NREQ-1:0] owner_mask, elig, gnt;
  logic [PW-1:0]   win;
  logic            accept, own_req, own_lock;

  // While locked only the owner is eligible; ARB_EN and reset block all grants.
  always_comb begin
    owner_mask          = '0;
    owner_mask[owner_q] = 1'b1;
    elig                = (state_q == ARB_OWN) ? (REQ & owner_mask) : REQ;
    if (!ARB_EN || RST) elig = '0;
  end

  rr_priority_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .req  (elig),
    .ptr  (ptr_q),
    .mode (RR_MODE),
    .gnt  (gnt)
  );

  always_comb begin
    win = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt[i]) win = PW'(i);
    end
  end

  assign GNT      = gnt;
  assign accept   = |gnt;
  assign own_req  = REQ[owner_q];
  assign own_lock = LOCK[owner_q];

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    lock_err_d = lock_err_q;
    if (accept) begin
      ptr_d = win;
      cnt_d = '0;
      if (LOCK[win]) begin
        state_d = ARB_OWN;
        owner_d = win;
      end else begin
        state_d = ARB_IDLE;
      end
    end else if (state_q == ARB_OWN && !own_req) begin
      if (own_lock) begin
        // Idle time is counted even with ARB_EN low so a stalled owner still times out.
        if (cnt_q == CW'(LOCK_TMO - 1)) begin
          state_d    = ARB_IDLE;
          cnt_d      = '0;
          lock_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else if (ARB_EN) begin
        state_d = ARB_IDLE;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ARB_IDLE;
      owner_q    <= '0;
      ptr_q      <= '0;
      cnt_q      <= '0;
      lock_err_q <= 1'b0;
      cen_q      <= 1'b1;
      wen_q      <= 1'b1;
      a_q        <= '0;
      d_q        <= '0;
      rd1_v_q    <= 1'b0;
      rd1_id_q   <= '0;
      rd2_v_q    <= 1'b0;
      rd2_id_q   <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      lock_err_q <= lock_err_d;
      if (accept) begin
        cen_q <= 1'b0;
        wen_q <= ~WE[win];
        a_q   <= ADDR[win*AW +: AW];
        d_q   <= WDATA[win*DW +: DW];
      end else begin
        cen_q <= 1'b1;
        wen_q <= 1'b1;
      end
      rd1_v_q  <= accept & ~WE[win];
      rd1_id_q <= win;
      rd2_v_q  <= rd1_v_q;
      rd2_id_q <= rd1_id_q;
    end
  end

  always_comb begin
    RVALID = '0;
    if (rd2_v_q) RVALID[rd2_id_q] = 1'b1;
  end

  assign RDATA    = Q;
  assign LOCK_ERR = lock_err_q;
  assign CEN      = cen_q;
  assign WEN      = wen_q;
  assign A        = a_q;
  assign D        = d_q;

  gnt_onehot: assert property (@(posedge CLK) disable iff (RST) $onehot0(GNT));

endmodule
